// File: rtl/pipeline_fetch.sv
// Instruction fetch stage: owns the PC, drives a synchronous word-addressed imem and
// presents one instruction per cycle to execute, honouring stall and branch redirect.
module pipeline_fetch #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'hF000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] imem_addr,
  output logic        imem_en,
  input  logic [15:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  output logic        instr_valid
);

  logic [15:0] fetch_pc;
  logic        resp_valid;
  logic [15:0] resp_pc;
  logic        held;
  logic [15:0] hold_instr;

  assign imem_addr = fetch_pc;
  // A redirect must fetch even under stall so the bubble lasts exactly one cycle.
  assign imem_en   = !rst && (!stall || redirect_valid);

  // The memory stops reading during a stall, so the response is captured on the first
  // stalled edge and replayed from hold_instr until release.
  assign instr       = held ? hold_instr : (resp_valid ? imem_rdata : NOP_INSTR);
  assign instr_pc    = resp_pc;
  assign instr_valid = resp_valid && !redirect_valid;

  // NOTE: all state updates use non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc   <= RESET_PC;
      resp_valid <= 1'b0;
      resp_pc    <= 16'h0000;
      held       <= 1'b0;
      hold_instr <= NOP_INSTR;
    end else if (redirect_valid) begin
      fetch_pc   <= redirect_pc;
      resp_valid <= 1'b0;
      held       <= 1'b0;
    end else if (stall) begin
      if (!held && resp_valid) begin
        hold_instr <= imem_rdata;
        held       <= 1'b1;
      end
    end else begin
      resp_valid <= 1'b1;
      resp_pc    <= fetch_pc;
      fetch_pc   <= fetch_pc + 16'd1;
      held       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pipeline_fetch.sv
// Directed bench for pipeline_fetch: a cycle-by-cycle vector table plus hand-written
// sequences for reset-during-stall and stall-during-bubble.
module tb_pipeline_fetch;

  localparam logic [15:0] NOP = 16'hF000;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] imem_addr;
  logic        imem_en;
  logic [15:0] imem_rdata;
  logic        stall;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;

  int checks = 0;
  int passed = 0;

  pipeline_fetch #(.RESET_PC(16'h0000), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_en(imem_en),
    .imem_rdata(imem_rdata), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid)
  );

  always #5 clk = ~clk;

  // Memory model: mem[a] = 16'h1000 + a; output is garbage on any edge without a read.
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= 16'h1000 + imem_addr;
    else         imem_rdata <= 16'($urandom);
  end

  typedef struct {
    logic        stall;
    logic        rv;
    logic [15:0] rpc;
    logic [15:0] exp_instr;
    logic [15:0] exp_pc;
    logic        exp_valid;
    logic [15:0] exp_addr;
  } vec_t;

  vec_t vecs[23];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [15:0] ei, input logic [15:0] ep,
                            input logic ev, input logic [15:0] ea);
    check({tag, " instr"}, instr, ei);
    check({tag, " instr_pc"}, instr_pc, ep);
    check({tag, " instr_valid"}, {15'd0, instr_valid}, {15'd0, ev});
    check({tag, " imem_addr"}, imem_addr, ea);
  endtask

  initial begin
    // stall, rv, rpc, instr, pc, valid, addr
    vecs[0]  = '{0, 0, 16'h0000, NOP,      16'h0000, 0, 16'h0000}; // bubble after reset
    vecs[1]  = '{0, 0, 16'h0000, 16'h1000, 16'h0000, 1, 16'h0001};
    vecs[2]  = '{0, 0, 16'h0000, 16'h1001, 16'h0001, 1, 16'h0002};
    vecs[3]  = '{0, 0, 16'h0000, 16'h1002, 16'h0002, 1, 16'h0003};
    vecs[4]  = '{0, 0, 16'h0000, 16'h1003, 16'h0003, 1, 16'h0004};
    vecs[5]  = '{1, 0, 16'h0000, 16'h1004, 16'h0004, 1, 16'h0005}; // stall x3, rdata corrupted
    vecs[6]  = '{1, 0, 16'h0000, 16'h1004, 16'h0004, 1, 16'h0005};
    vecs[7]  = '{1, 0, 16'h0000, 16'h1004, 16'h0004, 1, 16'h0005};
    vecs[8]  = '{0, 0, 16'h0000, 16'h1004, 16'h0004, 1, 16'h0005}; // release, still held
    vecs[9]  = '{0, 0, 16'h0000, 16'h1005, 16'h0005, 1, 16'h0006};
    vecs[10] = '{0, 1, 16'h0040, 16'h1006, 16'h0006, 0, 16'h0007}; // redirect, same-cycle squash
    vecs[11] = '{0, 0, 16'h0000, NOP,      16'h0006, 0, 16'h0040};
    vecs[12] = '{0, 0, 16'h0000, 16'h1040, 16'h0040, 1, 16'h0041};
    vecs[13] = '{0, 0, 16'h0000, 16'h1041, 16'h0041, 1, 16'h0042};
    vecs[14] = '{0, 1, 16'hFFFF, 16'h1042, 16'h0042, 0, 16'h0043}; // redirect to top of space
    vecs[15] = '{0, 0, 16'h0000, NOP,      16'h0042, 0, 16'hFFFF};
    vecs[16] = '{0, 0, 16'h0000, 16'h0FFF, 16'hFFFF, 1, 16'h0000}; // PC wraps
    vecs[17] = '{0, 0, 16'h0000, 16'h1000, 16'h0000, 1, 16'h0001};
    vecs[18] = '{0, 0, 16'h0000, 16'h1001, 16'h0001, 1, 16'h0002};
    vecs[19] = '{1, 0, 16'h0000, 16'h1002, 16'h0002, 1, 16'h0003}; // stall, captures hold
    vecs[20] = '{1, 1, 16'h0080, 16'h1002, 16'h0002, 0, 16'h0003}; // stall+redirect: redirect wins
    vecs[21] = '{0, 0, 16'h0000, NOP,      16'h0002, 0, 16'h0080}; // held cleared -> NOP
    vecs[22] = '{0, 0, 16'h0000, 16'h1080, 16'h0080, 1, 16'h0081};

    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    expect_out("reset", NOP, 16'h0000, 1'b0, 16'h0000);
    check("reset imem_en", {15'd0, imem_en}, 16'd0);

    rst = 1'b0;
    for (int i = 0; i < 23; i++) begin
      stall = vecs[i].stall;
      redirect_valid = vecs[i].rv;
      redirect_pc = vecs[i].rpc;
      #2;
      expect_out($sformatf("vec%0d", i), vecs[i].exp_instr, vecs[i].exp_pc,
                 vecs[i].exp_valid, vecs[i].exp_addr);
      step();
    end
    redirect_valid = 1'b0; redirect_pc = 16'h0000;

    // Reset during a 2-cycle stall, then a stall while the bubble is still in flight.
    stall = 1'b1;
    #2;
    expect_out("rststall c0", 16'h1081, 16'h0081, 1'b1, 16'h0082);
    check("stall imem_en", {15'd0, imem_en}, 16'd0);
    step();
    rst = 1'b1;
    #2;
    expect_out("rststall c1", 16'h1081, 16'h0081, 1'b1, 16'h0082);
    step();
    rst = 1'b0;
    #2;
    expect_out("after rst", NOP, 16'h0000, 1'b0, 16'h0000);
    check("bubble stall imem_en", {15'd0, imem_en}, 16'd0);
    step();
    stall = 1'b0;
    #2;
    expect_out("bubble release", NOP, 16'h0000, 1'b0, 16'h0000);
    check("run imem_en", {15'd0, imem_en}, 16'd1);
    step();
    #2;
    expect_out("restart0", 16'h1000, 16'h0000, 1'b1, 16'h0001);
    step();
    #2;
    expect_out("restart1", 16'h1001, 16'h0001, 1'b1, 16'h0002);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
